// File: rtl/wb_queue.sv
// Write-back queue: buffers pipeline results and retires one per cycle into the register file write port.
// Optional read-port forwarding of pending entries is enabled by defining WB_QUEUE_FORWARD_EN.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_busy,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] XZR = '1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic          push, store;

  assign in_ready = (count_q < CW'(DEPTH));
  assign we3      = (count_q != '0) & ~rf_busy;
  assign wa3      = (count_q != '0) ? addr_q[head_q] : '0;
  assign wd3      = (count_q != '0) ? data_q[head_q] : '0;
  assign count    = count_q;

  always_comb begin
    push    = in_valid & in_ready;
    // Writes to XZR complete the handshake but are never queued.
    store   = push & (in_addr != XZR);
    head_d  = we3 ? head_q + PW'(1) : head_q;
    tail_d  = store ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(store) - CW'(we3);
    addr_d  = addr_q;
    data_d  = data_q;
    if (store) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef WB_QUEUE_FORWARD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((addr_q[idx] == ra1) && (ra1 != XZR)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_q[idx];
        end
        if ((addr_q[idx] == ra2) && (ra2 != XZR)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back queue that owns the register file's single write port (we3/wa3/wd3) and is the writer-side counterpart of the 32x64 register file's read ports.
- Accepts 64-bit results from the pipeline through a valid/ready handshake and buffers them in a small FIFO.
- Retires at most one entry per cycle into the register file, stalling when the port is borrowed.
- Optionally forwards pending, not-yet-written values to the two read lookups.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 5, register address width (32 registers; X31 = XZR).
- DW, 64, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a result.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_addr  in  AW  destination register.
- in_data  in  DW  result value.
- rf_busy  in  1  write port is unavailable this cycle; blocks retirement.
- we3  out  1  register file write enable.
- wa3  out  AW  register file write address.
- wd3  out  DW  register file write data.
- ra1, ra2  in  AW  read addresses presented to the register file (forwarding lookup).
- fwd1_hit, fwd2_hit  out  1  a pending entry matches ra1 / ra2.
- fwd1_data, fwd2_data  out  DW  value of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): head, tail and count go to 0; we3=0; in_ready=1; fwd*_hit=0. Entries are invalidated and data contents are don't-care. Reset mid-stream discards all pending writes with no partial write.
- Push: occurs when in_valid & in_ready at a rising edge. Entry {in_addr, in_data} is stored at tail and tail increments modulo DEPTH.
- XZR drop: a handshake with in_addr==31 completes (consumes the beat) but nothing is stored and count is unchanged.
- Retire:
  - we3 = (count!=0) & !rf_busy, combinational.
  - wa3/wd3 are driven from the head entry and are 0 when empty.
  - At each rising edge with we3=1, head increments modulo DEPTH. The register file captures the same edge.
- Latency: a value accepted at edge N into an empty queue with rf_busy=0 is written at edge N+1 and is readable from the register file after N+1.
- Ordering is strict FIFO; entries with the same address retire oldest first.
- Simultaneous push and retire: count is unchanged. This is also legal when count==DEPTH, but in_ready stays 0 when full, so no push occurs at full.
- Full (count==DEPTH): in_ready=0 and in_data is ignored.
- Empty: we3=0.
- rf_busy held high: the queue fills and then backpressures, and no entry is lost.
- count is updated as count + push_stored - retire. It never exceeds DEPTH and never underflows.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro: WB_QUEUE_FORWARD_EN.
- Defined:
  - fwdN_hit=1 when any valid entry has addr==raN and raN!=31.
  - fwdN_data is the youngest matching entry (closest to tail), combinational.
  - The head entry being retired in the current cycle still counts as a hit.
- Undefined: fwd*_hit are tied to 0 and fwd*_data to 0; ra1/ra2 are unused.

Test Plan:
- Reset then single write: push addr 4, data 0x0123_4567_89AB_CDEF with rf_busy=0 -> next cycle we3=1, wa3=4, wd3=0x0123...CDEF; count returns to 0.
- XZR: push addr 31, data 0xFEDC_BA98_7654_3210 -> in_ready stays 1, count stays 0, and we3 never asserts.
- Backpressure: hold rf_busy=1 and push addrs 1,2,3,4,5 -> count=4 and in_ready=0 after the 4th; the 5th is held by the producer. Release rf_busy -> we3 asserts on 4 consecutive cycles with wa3=1,2,3,4, then 5 follows; wrap-around is covered.
- Forwarding (macro on): with rf_busy=1, push addr 7 = 0xAAAA then addr 7 = 0xBBBB, and set ra1=7, ra2=31 -> fwd1_hit=1, fwd1_data=0xBBBB, fwd2_hit=0. Macro off -> both hits are 0.
- Simultaneous push and retire at count==3: count stays 3 and FIFO order is preserved.
- Async reset mid-stream: assert rst_n=0 between clock edges with 3 entries pending -> we3=0, count=0, in_ready=1 immediately, and no stale writes occur after release.
